mant_align_pipe: RTL and testbench
==================================

Name: mant_align_pipe

Overview:
- Two-stage pipelined alignment stage directly downstream of the 4-input max-exponent comparator in the GEMM datapath.
- Takes four small-float operands plus their shared maximum exponent (the comparator output).
- Right-shifts each significand by (max_exp - exp_i), keeping guard and sticky bits, so the adder tree can sum the lanes as fixed-point values.
- Valid/ready handshake on both sides, with full back-pressure support.

Parameters:
- EXP_W, 3, exponent width per lane; equals the comparator's expWidth.
- MAN_W, 3, stored fraction width per lane; the hidden bit is added internally.
- GRD_W, 2, guard bits appended below the significand before shifting.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  4  sign per lane; lane i is bit i.
- in_exp  in  4*EXP_W  exponent per lane; lane i is bits [EXP_W*i +: EXP_W].
- in_man  in  4*MAN_W  fraction per lane; lane i is bits [MAN_W*i +: MAN_W].
- in_max_exp  in  EXP_W  maximum exponent of the four lanes, from the comparator.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_sign  out  4  signs, delayed to match the data.
- out_mag  out  4*ALN_W  aligned magnitudes; ALN_W = MAN_W+GRD_W+2.
- out_exp  out  EXP_W  block exponent (the registered in_max_exp).
- out_err  out  1  some lane had exp_i > in_max_exp in this beat.

Behaviour:
- Reset: all valids, out_mag, out_sign, out_exp and out_err clear to 0. in_ready is 1 one cycle after rst_n deasserts.
- Mid-operation reset: in-flight beats are discarded and nothing is emitted after release.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - Stage k advances when its output slot is empty or is being consumed.
  - in_ready = !s1_valid || s1_advance, which is combinational from out_ready through the pipeline.
  - While out_valid=1 && out_ready=0, all outputs hold stable.
  - Throughput is one beat per cycle; latency is 2 cycles from input acceptance to out_valid.
- Stage 1, on accept:
  - Register sign, max_exp and the per-lane significand sig_i = {hid_i, man_i}, where hid_i = (exp_i != 0).
  - Register per-lane zero_i = (exp_i == 0).
  - Register sh_i = max_exp - exp_i as an unsigned EXP_W-bit value, clamped to 0 and flagging err_i when exp_i > max_exp.
- Stage 2:
  - Form ext_i = {sig_i, GRD_W'b0} (MAN_W+1+GRD_W bits).
  - Compute ext_i >> sh_i.
  - Sticky = OR of all bits shifted out.
  - Output out_mag_i = {shifted, sticky}.
  - If sh_i >= MAN_W+1+GRD_W, the shifted field is 0 and sticky = |sig_i.
  - If zero_i, out_mag_i = 0 regardless of shift.
  - out_err = OR of err_i.
- Simultaneous accept and emit in the same cycle is allowed; there are no bubbles under continuous valid/ready.

Decomposition:
- Shared package holds ALN_W, the lane count 4, and the lane slice helper macros/functions reused by the comparator and the adder tree.
- One natural sub-module, lane_shifter: combinational per-lane shift with sticky, instantiated 4 times in a generate loop. Pipeline registers and handshake stay in the top.

Test Plan (all with defaults, ALN_W=7):
1. Lane0 exp=5, max=5, man=3'b101 -> out_mag lane0 = 7'b1101000, out_exp=5, out_err=0, out_valid exactly 2 cycles after accept.
2. Lane1 exp=3, max=5, man=3'b000 -> 7'b0010000 (sticky 0). Lane2 exp=1, max=5, man=3'b011 -> 7'b0000101 (sticky 1).
3. Lane3 exp=0 (zero) -> 7'b0000000. Lane with exp=1, max=7, sh=6 (saturation) -> 7'b0000001.
4. Back-pressure: stream 5 beats with out_ready held 0 for 4 cycles. Expect in_ready=0 after two beats are held, and all 5 beats emerge in order with no loss or duplication.
5. Inconsistent input: exp=6, max=4 -> that lane is unshifted (sh=0) and out_err=1 on that beat only.
6. Assert rst_n low while 2 beats are in flight -> out_valid=0 immediately and stays 0 after release until new input arrives.

Source files
------------

// File: rtl/mant_align_pipe_pkg.sv
// rtl/mant_align_pipe_pkg.sv - shared lane constants and slice helpers for the GEMM alignment datapath
package mant_align_pipe_pkg;

    localparam int LANES       = 4;
    localparam int DEF_EXP_W   = 3;
    localparam int DEF_MAN_W   = 3;
    localparam int DEF_GRD_W   = 2;

    // Aligned magnitude: hidden bit + fraction + guard bits + sticky.
    function automatic int aln_w(input int man_w, input int grd_w);
        return man_w + grd_w + 2;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mant_align_pipe_lane_shifter.sv
// rtl/mant_align_pipe_lane_shifter.sv - combinational per-lane right shift with sticky
module mant_align_pipe_lane_shifter
    import mant_align_pipe_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int GRD_W = DEF_GRD_W,
    localparam int EXT_W = MAN_W + 1 + GRD_W,
    localparam int ALN_W = EXT_W + 1
) (
    input  logic [MAN_W:0]     sig_i,
    input  logic [EXP_W-1:0]   sh_i,
    input  logic               zero_i,
    output logic [ALN_W-1:0]   mag_o
);

    logic [EXT_W-1:0]   ext;
    logic [2*EXT_W-1:0] wide;
    logic               sat;

    // The low half of wide collects every bit shifted out, so its OR is the sticky.
    always_comb begin
        ext  = {sig_i, {GRD_W{1'b0}}};
        wide = {ext, {EXT_W{1'b0}}} >> sh_i;
        sat  = 32'(sh_i) >= EXT_W;
        if (zero_i) begin
            mag_o = '0;
        end else if (sat) begin
            mag_o = {{EXT_W{1'b0}}, |sig_i};
        end else begin
            mag_o = {wide[2*EXT_W-1:EXT_W], |wide[EXT_W-1:0]};
        end
    end

endmodule

// File: rtl/mant_align_pipe.sv
// rtl/mant_align_pipe.sv - two-stage significand alignment to the block max exponent
module mant_align_pipe
    import mant_align_pipe_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int GRD_W = DEF_GRD_W,
    localparam int ALN_W = aln_w(MAN_W, GRD_W),
    localparam int SIG_W = MAN_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_sign,
    input  logic [LANES*EXP_W-1:0] in_exp,
    input  logic [LANES*MAN_W-1:0] in_man,
    input  logic [EXP_W-1:0]       in_max_exp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_sign,
    output logic [LANES*ALN_W-1:0] out_mag,
    output logic [EXP_W-1:0]       out_exp,
    output logic                   out_err
);

    logic                   s1_valid_q, s1_valid_d;
    logic [LANES-1:0]       s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]       s1_exp_q,   s1_exp_d;
    logic [LANES*SIG_W-1:0] s1_sig_q,   s1_sig_d;
    logic [LANES-1:0]       s1_zero_q,  s1_zero_d;
    logic [LANES*EXP_W-1:0] s1_sh_q,    s1_sh_d;
    logic [LANES-1:0]       s1_err_q,   s1_err_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [LANES-1:0]       s2_sign_q,  s2_sign_d;
    logic [LANES*ALN_W-1:0] s2_mag_q,   s2_mag_d;
    logic [EXP_W-1:0]       s2_exp_q,   s2_exp_d;
    logic                   s2_err_q,   s2_err_d;

    logic                   s2_free;
    logic [LANES*ALN_W-1:0] lane_mag;

    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_sig_d   = s1_sig_q;
        s1_zero_d  = s1_zero_q;
        s1_sh_d    = s1_sh_q;
        s1_err_d   = s1_err_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            s1_sign_d = in_sign;
            s1_exp_d  = in_max_exp;
            for (int i = 0; i < LANES; i++) begin
                // An exponent above the reported max is a comparator fault; leave the lane unshifted.
                s1_err_d[i]  = in_exp[lane_lsb(i, EXP_W) +: EXP_W] > in_max_exp;
                s1_zero_d[i] = in_exp[lane_lsb(i, EXP_W) +: EXP_W] == '0;
                s1_sh_d[lane_lsb(i, EXP_W) +: EXP_W] = s1_err_d[i] ? '0
                    : in_max_exp - in_exp[lane_lsb(i, EXP_W) +: EXP_W];
                s1_sig_d[lane_lsb(i, SIG_W) +: SIG_W] =
                    {!s1_zero_d[i], in_man[lane_lsb(i, MAN_W) +: MAN_W]};
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mant_align_pipe_lane_shifter #(
            .EXP_W (EXP_W),
            .MAN_W (MAN_W),
            .GRD_W (GRD_W)
        ) u_shift (
            .sig_i  (s1_sig_q[g*SIG_W +: SIG_W]),
            .sh_i   (s1_sh_q[g*EXP_W +: EXP_W]),
            .zero_i (s1_zero_q[g]),
            .mag_o  (lane_mag[g*ALN_W +: ALN_W])
        );
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_mag_d   = s2_mag_q;
        s2_exp_d   = s2_exp_q;
        s2_err_d   = s2_err_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_free && s1_valid_q) begin
            s2_sign_d = s1_sign_q;
            s2_mag_d  = lane_mag;
            s2_exp_d  = s1_exp_q;
            s2_err_d  = |s1_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= '0;
            s1_exp_q   <= '0;
            s1_sig_q   <= '0;
            s1_zero_q  <= '0;
            s1_sh_q    <= '0;
            s1_err_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= '0;
            s2_mag_q   <= '0;
            s2_exp_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_sig_q   <= s1_sig_d;
            s1_zero_q  <= s1_zero_d;
            s1_sh_q    <= s1_sh_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_mag_q   <= s2_mag_d;
            s2_exp_q   <= s2_exp_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = s2_sign_q;
    assign out_mag   = s2_mag_q;
    assign out_exp   = s2_exp_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_mant_align_pipe.sv
// tb/tb_mant_align_pipe.sv - directed self-checking bench for mant_align_pipe
module tb_mant_align_pipe;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sign;
    logic [11:0]      in_exp;
    logic [11:0]      in_man;
    logic [2:0]       in_max_exp;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_sign;
    logic [27:0]      out_mag;
    logic [2:0]       out_exp;
    logic             out_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]       sign;
        logic [3:0][2:0]  exp;
        logic [3:0][2:0]  man;
        logic [2:0]       max;
        logic [3:0][6:0]  mag;
        logic             err;
    } vec_t;

    vec_t tbl[5];

    mant_align_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .in_max_exp (in_max_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_mag    (out_mag),
        .out_exp    (out_exp),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] sign, input logic [11:0] exp,
                                input logic [11:0] man, input logic [2:0] max,
                                input logic [27:0] mag, input logic err);
        vec_t v;
        v.sign = sign; v.exp = exp; v.man = man; v.max = max; v.mag = mag; v.err = err;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        chk($sformatf("v%0d_idle_out_valid", idx), 32'(out_valid), 32'd0);
        in_sign = v.sign; in_exp = v.exp; in_man = v.man; in_max_exp = v.max;
        in_valid = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d_lat1_out_valid", idx), 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_out_mag", idx), 32'(out_mag), 32'(v.mag));
        chk($sformatf("v%0d_out_exp", idx), 32'(out_exp), 32'(v.max));
        chk($sformatf("v%0d_out_err", idx), 32'(out_err), 32'(v.err));
        chk($sformatf("v%0d_out_sign", idx), 32'(out_sign), 32'(v.sign));
    endtask

    task automatic drive_tag(input int j);
        in_sign    = 4'(j);
        in_exp     = {3'd0, 3'd0, 3'd0, 3'd5};
        in_man     = {9'd0, 3'(j)};
        in_max_exp = 3'd5;
        in_valid   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int beat_in;
        int beat_out;
        bit acc_in;

        //            sign     exp {l3,l2,l1,l0}         man {l3,l2,l1,l0}              max   mag {l3,l2,l1,l0}                                 err
        tbl[0] = mk(4'b1010, {3'd0,3'd1,3'd3,3'd5}, {3'b111,3'b011,3'b000,3'b101}, 3'd5, {7'b0000000,7'b0000101,7'b0010000,7'b1101000}, 1'b0);
        tbl[1] = mk(4'b0101, {3'd2,3'd6,3'd7,3'd1}, {3'b110,3'b010,3'b111,3'b000}, 3'd7, {7'b0000011,7'b0101000,7'b1111000,7'b0000001}, 1'b0);
        tbl[2] = mk(4'b1111, {3'd3,3'd2,3'd4,3'd6}, {3'b100,3'b111,3'b000,3'b001}, 3'd4, {7'b0110000,7'b0011110,7'b1000000,7'b1001000}, 1'b1);
        tbl[3] = mk(4'b0000, {3'd4,3'd3,3'd1,3'd0}, {3'b011,3'b001,3'b111,3'b000}, 3'd4, {7'b1011000,7'b0100100,7'b0001111,7'b0000000}, 1'b0);
        tbl[4] = mk(4'b0011, {3'd3,3'd7,3'd0,3'd1}, {3'b001,3'b000,3'b000,3'b111}, 3'd7, {7'b0000101,7'b1000000,7'b0000000,7'b0000001}, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = '0; in_exp = '0; in_man = '0; in_max_exp = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mag",   32'(out_mag),   32'd0);
        chk("rst_out_sign",  32'(out_sign),  32'd0);
        chk("rst_out_exp",   32'(out_exp),   32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], i);
        end

        beat_in = 0; beat_out = 0;
        for (int cyc = 0; cyc < 40 && beat_out < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            if (beat_in < 5) drive_tag(beat_in);
            else in_valid = 1'b0;
            #1;
            if (cyc == 2 || cyc == 3) chk($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
            if (cyc == 3) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_sign",  32'(out_sign),  32'd0);
                chk("bp_hold_mag",   32'(out_mag),   32'b1000000);
            end
            acc_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_tag_%0d", beat_out), 32'(out_sign), 32'(beat_out));
                chk($sformatf("bp_mag_%0d", beat_out), 32'(out_mag), {25'd0, 1'b1, 3'(beat_out), 3'b000});
                chk($sformatf("bp_exp_%0d", beat_out), 32'(out_exp), 32'd5);
                beat_out++;
            end
            @(posedge clk);
            if (acc_in) beat_in++;
        end
        chk("bp_beat_count", 32'(beat_out), 32'd5);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_no_dup_%0d", k), 32'(out_valid), 32'd0);
        end

        out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            drive_tag(j + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_pre_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_out_valid", 32'(out_valid), 32'd0);
        chk("mr_async_out_mag",   32'(out_mag),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mr_quiet_%0d", k), 32'(out_valid), 32'd0);
        end
        run_vec(tbl[0], 5);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
